// File: rtl/btb_update_queue_pkg.sv
// Shared types and sizing for the BTB update queue.
package btb_update_queue_pkg;
    localparam int BTB_ADDR_W   = 32;
    localparam int BTB_UQ_DEPTH = 4;
    localparam int BTB_UQ_PTR_W = 2;
    localparam int BTB_UQ_CNT_W = 16;

    typedef struct packed {
        logic [BTB_ADDR_W-1:0] eip;
        logic [BTB_ADDR_W-1:0] fip_e;
        logic [BTB_ADDR_W-1:0] fip_o;
        logic [BTB_ADDR_W-1:0] target;
    } btb_upd_t;
endpackage

// File: rtl/btb_update_queue_if.sv
// WB-side update handshake and BTB write-port signals around the update queue.
interface btb_update_queue_if;
    import btb_update_queue_pkg::*;

    logic                  wb_valid;
    logic                  wb_is_br;
    logic                  wb_taken;
    logic [BTB_ADDR_W-1:0] wb_eip;
    logic [BTB_ADDR_W-1:0] wb_fip_e;
    logic [BTB_ADDR_W-1:0] wb_fip_o;
    logic [BTB_ADDR_W-1:0] wb_target;
    logic                  wb_ready;
    logic                  btb_hold;
    logic                  btb_ld;
    logic [BTB_ADDR_W-1:0] btb_eip;
    logic [BTB_ADDR_W-1:0] btb_fip_e;
    logic [BTB_ADDR_W-1:0] btb_fip_o;
    logic [BTB_ADDR_W-1:0] btb_target;

    // master: pipeline/BTB environment; slave: the queue itself
    modport master (
        output wb_valid, wb_is_br, wb_taken, wb_eip, wb_fip_e, wb_fip_o, wb_target, btb_hold,
        input  wb_ready, btb_ld, btb_eip, btb_fip_e, btb_fip_o, btb_target
    );
    modport slave (
        input  wb_valid, wb_is_br, wb_taken, wb_eip, wb_fip_e, wb_fip_o, wb_target, btb_hold,
        output wb_ready, btb_ld, btb_eip, btb_fip_e, btb_fip_o, btb_target
    );
endinterface

// File: rtl/btb_uq_storage.sv
// Entry register file: one write port at tail, one registered-state read port at head.
module btb_uq_storage
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH = BTB_UQ_DEPTH,
    parameter int PTR_W = BTB_UQ_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  btb_upd_t         wdata,
    input  logic [PTR_W-1:0] raddr,
    output btb_upd_t         rdata
);
    btb_upd_t mem [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst)
                mem[g] <= '0;
            else if (we && waddr == PTR_W'(g))
                mem[g] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/btb_update_queue.sv
// Buffers taken-branch updates from WB and drains one per cycle into the BTB write port,
// suppressing back-to-back duplicates and discarding everything on a context-switch flush.
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH = BTB_UQ_DEPTH,
    parameter int PTR_W = BTB_UQ_PTR_W,
    parameter int CNT_W = BTB_UQ_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    btb_update_queue_if.slave  bus,
    output logic [PTR_W:0]     occupancy,
    output logic [CNT_W-1:0]   drop_cnt
);
    logic [PTR_W-1:0]      head, tail;
    logic [PTR_W:0]        count;
    logic                  last_vld;
    logic [BTB_ADDR_W-1:0] last_eip, last_tgt;
    logic                  push_req, dup, do_write, pop;
    btb_upd_t              wdata, rdata;

    assign bus.wb_ready = (count != (PTR_W+1)'(DEPTH));
    assign push_req     = bus.wb_valid & bus.wb_is_br & bus.wb_taken & bus.wb_ready & ~flush;
    assign dup          = last_vld & (bus.wb_eip == last_eip) & (bus.wb_target == last_tgt);
    assign do_write     = push_req & ~dup;
    assign pop          = (count != '0) & ~bus.btb_hold & ~flush;

    assign wdata = '{eip: bus.wb_eip, fip_e: bus.wb_fip_e, fip_o: bus.wb_fip_o,
                     target: bus.wb_target};

    btb_uq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
        .clk   (clk),
        .rst   (rst),
        .we    (do_write),
        .waddr (tail),
        .wdata (wdata),
        .raddr (head),
        .rdata (rdata)
    );

    assign bus.btb_ld     = pop;
    assign bus.btb_eip    = rdata.eip;
    assign bus.btb_fip_e  = rdata.fip_e;
    assign bus.btb_fip_o  = rdata.fip_o;
    assign bus.btb_target = rdata.target;
    assign occupancy      = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            last_vld <= 1'b0;
            last_eip <= '0;
            last_tgt <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            // drop_cnt is a statistic across contexts, so it survives the flush
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            last_vld <= 1'b0;
        end else begin
            if (do_write) begin
                tail     <= tail + 1'b1;
                last_eip <= bus.wb_eip;
                last_tgt <= bus.wb_target;
                last_vld <= 1'b1;
            end
            if (push_req && dup && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
            if (pop)
                head <= head + 1'b1;
            count <= count + (PTR_W+1)'(do_write) - (PTR_W+1)'(pop);
        end
    end
endmodule
